// File: rtl/err_inj_pkg.sv
// Shared types, constants and helpers for the channel error injector.
package err_inj_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    PERIODIC = 2'd1,
    RANDOM   = 2'd2,
    ONESHOT  = 2'd3
  } err_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } oneshot_state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  // Right-shifting Galois step: the bit shifted out decides whether the taps are folded in.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/err_inj_lfsr.sv
// 16-bit Galois LFSR with reset seed and advance enable.
module err_inj_lfsr
  import err_inj_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/channel_err_inj.sv
// Channel error injector: OFF / PERIODIC / RANDOM / ONESHOT corruption of a symbol stream.
// Define ERR_INJ_STATS_EN to build the flip and symbol counters; otherwise they read zero.
module channel_err_inj
  import err_inj_pkg::*;
#(
  parameter int unsigned       SYM_W       = 2,
  parameter int unsigned       PERIOD      = 256,
  parameter int unsigned       BURST_START = 247,
  parameter int unsigned       BURST_LEN   = 9,
  parameter logic [SYM_W-1:0]  FLIP_MASK   = {SYM_W{1'b1}},
  parameter logic [15:0]       LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode_i,
  input  logic [7:0]       cfg_thresh_i,
  input  logic             arm_i,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic             err_o,
  output logic [31:0]      flip_ct_o,
  output logic [31:0]      sym_ct_o
);

  localparam int unsigned POS_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned BL_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [POS_W:0]   START_X  = (POS_W + 1)'(BURST_START);
  localparam logic [POS_W:0]   LEN_X    = (POS_W + 1)'(BURST_LEN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(PERIOD - 1);
  localparam logic [BL_W-1:0]  CNT_LAST = BL_W'(BURST_LEN - 1);

  if ((BURST_LEN == 0) || (BURST_START + BURST_LEN > PERIOD) || (LFSR_SEED == 16'h0000) ||
      (SYM_W < 1) || (SYM_W > 16) || ((SYM_W & (SYM_W - 1)) != 0)) begin : g_bad_cfg
    $error("channel_err_inj: illegal parameter combination");
  end

  err_mode_t       mode_s;
  err_mode_t       mode_q;
  logic            mode_chg_s;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic [POS_W:0]   pos_off_s;
  logic [15:0]     lfsr_s;
  logic [7:0]      rnd_idx_s;
  oneshot_state_t  os_state_q;
  oneshot_state_t  os_state_d;
  logic [BL_W-1:0] burst_cnt_q;
  logic [BL_W-1:0] burst_cnt_d;
  logic            os_active_s;
  logic            os_fire_s;
  logic [SYM_W-1:0] f_s;
  logic            valid_q;
  logic [SYM_W-1:0] sym_q;
  logic            err_q;

  assign mode_s     = err_mode_t'(cfg_mode_i);
  assign mode_chg_s = valid_i && (mode_s != mode_q);

  err_inj_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (valid_i),
    .state_o (lfsr_s)
  );

  always_comb begin
    if (!valid_i) begin
      pos_d = pos_q;
    end else if (pos_q == POS_LAST) begin
      pos_d = '0;
    end else begin
      pos_d = pos_q + POS_W'(1);
    end
  end

  // Mode seen at the last valid symbol, used to detect a mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q  <= '0;
      mode_q <= OFF;
    end else begin
      pos_q <= pos_d;
      if (valid_i) begin
        mode_q <= mode_s;
      end else begin
        mode_q <= mode_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_state_q  <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      os_state_q  <= os_state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    os_state_d  = os_state_q;
    burst_cnt_d = burst_cnt_q;
    if (mode_chg_s) begin
      os_state_d  = IDLE;
      burst_cnt_d = '0;
    end else begin
      case (os_state_q)
        IDLE, DONE: begin
          if (arm_i && (mode_s == ONESHOT)) begin
            os_state_d  = ARMED;
            burst_cnt_d = '0;
          end else begin
            os_state_d  = os_state_q;
          end
        end
        ARMED, BURST: begin
          if (os_fire_s && (burst_cnt_q == CNT_LAST)) begin
            os_state_d  = DONE;
            burst_cnt_d = '0;
          end else if (os_fire_s) begin
            os_state_d  = BURST;
            burst_cnt_d = burst_cnt_q + BL_W'(1);
          end else begin
            os_state_d  = os_state_q;
          end
        end
        default: begin
          os_state_d  = IDLE;
          burst_cnt_d = '0;
        end
      endcase
    end
  end

  // ARMED already corrupts: the symbol that leaves ARMED is the first of the burst.
  always_comb begin
    case (os_state_q)
      ARMED, BURST: os_active_s = 1'b1;
      default:      os_active_s = 1'b0;
    endcase
  end

  assign os_fire_s = valid_i && !mode_chg_s && (mode_s == ONESHOT) && os_active_s;
  assign pos_off_s = {1'b0, pos_q} - START_X;
  assign rnd_idx_s = lfsr_s[15:8] & 8'(SYM_W - 1);

  always_comb begin
    f_s = '0;
    case (mode_s)
      OFF: f_s = '0;
      PERIODIC: begin
        if (pos_off_s < LEN_X) begin
          f_s = FLIP_MASK;
        end else begin
          f_s = '0;
        end
      end
      RANDOM: begin
        if (lfsr_s[7:0] < cfg_thresh_i) begin
          f_s = SYM_W'(1) << rnd_idx_s;
        end else begin
          f_s = '0;
        end
      end
      ONESHOT: begin
        if (os_fire_s) begin
          f_s = FLIP_MASK;
        end else begin
          f_s = '0;
        end
      end
      default: f_s = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sym_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        sym_q <= sym_i ^ f_s;
        err_q <= |f_s;
      end else begin
        sym_q <= sym_q;
        err_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign sym_o   = sym_q;
  assign err_o   = err_q;

`ifdef ERR_INJ_STATS_EN
  logic [31:0] flip_q;
  logic [31:0] flip_d;
  logic [31:0] symct_q;
  logic [31:0] symct_d;
  logic [32:0] flip_sum_s;

  assign flip_sum_s = {1'b0, flip_q} + {28'd0, popcount16(16'(f_s))};

  always_comb begin
    if (!valid_i) begin
      flip_d  = flip_q;
      symct_d = symct_q;
    end else begin
      flip_d  = flip_sum_s[32] ? 32'hFFFF_FFFF : flip_sum_s[31:0];
      symct_d = (symct_q == 32'hFFFF_FFFF) ? symct_q : symct_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_q  <= 32'd0;
      symct_q <= 32'd0;
    end else begin
      flip_q  <= flip_d;
      symct_q <= symct_d;
    end
  end

  assign flip_ct_o = flip_q;
  assign sym_ct_o  = symct_q;
`else
  assign flip_ct_o = 32'd0;
  assign sym_ct_o  = 32'd0;
`endif

endmodule

// File: tb/tb_channel_err_inj.sv
// Directed self-checking bench for channel_err_inj at default parameters.
module tb_channel_err_inj;

`ifdef ERR_INJ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode_i = 2'd0;
  logic [7:0]  cfg_thresh_i = 8'd0;
  logic        arm_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  sym_i = 2'd0;
  logic        valid_o;
  logic [1:0]  sym_o;
  logic        err_o;
  logic [31:0] flip_ct_o;
  logic [31:0] sym_ct_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned k;
  int unsigned m_flip;
  int unsigned m_sym;
  int unsigned seen_err;
  int unsigned m_hits;
  logic [15:0] m_lfsr;

  channel_err_inj dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_thresh_i (cfg_thresh_i),
    .arm_i        (arm_i),
    .valid_i      (valid_i),
    .sym_i        (sym_i),
    .valid_o      (valid_o),
    .sym_o        (sym_o),
    .err_o        (err_o),
    .flip_ct_o    (flip_ct_o),
    .sym_ct_o     (sym_ct_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int unsigned v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  function automatic logic [1:0] per_f(input int unsigned idx);
    return ((idx % 256) >= 247) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [1:0] rand_f(input logic [7:0] th);
    if (m_lfsr[7:0] < th) return m_lfsr[8] ? 2'b10 : 2'b01;
    else return 2'b00;
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    valid_i = 1'b0;
    arm_i = 1'b0;
    #1;
    check({tag, "/valid_o"}, 32'(valid_o), 32'd0);
    check({tag, "/sym_o"}, 32'(sym_o), 32'd0);
    check({tag, "/err_o"}, 32'(err_o), 32'd0);
    check({tag, "/flip_ct"}, flip_ct_o, 32'd0);
    check({tag, "/sym_ct"}, sym_ct_o, 32'd0);
    k = 0;
    m_flip = 0;
    m_sym = 0;
    m_lfsr = 16'hACE1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic a, input logic [1:0] f,
                      input string tag);
    @(negedge clk);
    valid_i = v;
    sym_i = s;
    arm_i = a;
    @(posedge clk);
    #1;
    check({tag, "/valid_o"}, 32'(valid_o), 32'(v));
    if (v) begin
      check({tag, "/sym_o"}, 32'(sym_o), 32'(s ^ f));
      check({tag, "/err_o"}, 32'(err_o), 32'(|f));
      if (err_o === 1'b1) seen_err++;
      m_sym++;
      m_flip += int'(f[0]) + int'(f[1]);
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      k++;
    end
    check({tag, "/flip_ct"}, flip_ct_o, stat(m_flip));
    check({tag, "/sym_ct"}, sym_ct_o, stat(m_sym));
  endtask

  initial begin
    logic [1:0] f;
    logic       v;

    do_reset("reset");

    // Periodic burst over the first frame and into the second.
    cfg_mode_i = 2'd1;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'(i ^ (i >> 2)), 1'b0, per_f(k), "periodic");
      if (i == 255) check("periodic/flip_at_255", flip_ct_o, stat(18));
    end

    do_reset("reset_off");
    cfg_mode_i = 2'd0;
    for (int i = 0; i < 1000; i++) step(1'b1, 2'(i * 7 + 1), 1'b0, 2'b00, "off");
    check("off/sym_ct_1000", sym_ct_o, stat(1000));

    // One-shot: arm with valid at 10, re-arm ignored at 14, arm from DONE before 30.
    do_reset("reset_oneshot");
    cfg_mode_i = 2'd3;
    for (int i = 0; i < 50; i++) begin
      if (i == 30) step(1'b0, 2'b00, 1'b1, 2'b00, "oneshot_arm_idle");
      f = ((i >= 11 && i <= 19) || (i >= 30 && i <= 38)) ? 2'b11 : 2'b00;
      step(1'b1, 2'(i + 2), (i == 10 || i == 14), f, "oneshot");
    end
    check("oneshot/flip_36", flip_ct_o, stat(36));
    // Burst aborted by a mode change; returning to ONESHOT does not resume it.
    for (int i = 50; i < 60; i++) begin
      if (i == 55) cfg_mode_i = 2'd0;
      if (i == 57) cfg_mode_i = 2'd3;
      f = (i == 53 || i == 54) ? 2'b11 : 2'b00;
      step(1'b1, 2'(i), (i == 52), f, "oneshot_abort");
    end
    check("oneshot_abort/flip_40", flip_ct_o, stat(40));

    do_reset("reset_random");
    cfg_mode_i = 2'd2;
    cfg_thresh_i = 8'd0;
    seen_err = 0;
    for (int i = 0; i < 4096; i++) step(1'b1, 2'(i), 1'b0, rand_f(8'd0), "random_t0");
    check("random_t0/no_flips", seen_err, 32'd0);
    cfg_thresh_i = 8'd255;
    seen_err = 0;
    m_hits = 0;
    for (int i = 0; i < 4096; i++) begin
      f = rand_f(8'd255);
      if (f != 2'b00) m_hits++;
      step(1'b1, 2'(i * 3), 1'b0, f, "random_t255");
    end
    check("random_t255/flips_vs_model", seen_err, m_hits);
    check("random_t255/rate_near_4080", 32'(seen_err >= 4050 && seen_err <= 4096), 32'd1);

    // Reset in the middle of a periodic burst, then a full frame again.
    do_reset("reset_midburst_pre");
    cfg_mode_i = 2'd1;
    for (int i = 0; i <= 250; i++) step(1'b1, 2'(i), 1'b0, per_f(k), "midburst");
    do_reset("midburst_rst");
    for (int i = 0; i < 256; i++) step(1'b1, 2'(i + 1), 1'b0, per_f(k), "after_rst");
    check("after_rst/flip_18", flip_ct_o, stat(18));

    // Gapped input: state advances only on valid cycles; pos carries across modes.
    do_reset("reset_gapped");
    cfg_mode_i = 2'd2;
    cfg_thresh_i = 8'd128;
    for (int i = 0; i < 200; i++) begin
      v = (i % 2 == 0);
      f = v ? rand_f(8'd128) : 2'b00;
      step(v, 2'(i), 1'b0, f, "gapped_random");
    end
    cfg_mode_i = 2'd1;
    for (int i = 0; i < 600; i++) begin
      v = (i % 2 == 1);
      f = v ? per_f(k) : 2'b00;
      step(v, 2'(i + 3), 1'b0, f, "gapped_periodic");
    end
    check("gapped/sym_ct_400", sym_ct_o, stat(400));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/channel_err_inj.md
# channel_err_inj

- Parametrised channel error injector for the encoder-to-decoder symbol path in the Viterbi test harnesses.
- Takes one SYM_W-bit coded symbol per valid cycle and returns it one cycle later, possibly corrupted.
- Four modes: pass-through, periodic burst, one-shot armed burst, pseudo-random single-bit flips.
- Flags every corrupted symbol and counts injected bit flips, so benches can correlate decoder output errors with channel errors.

## Interface
Parameters:
- SYM_W, 2: bits per coded symbol; power of two, 1..16.
- PERIOD, 256: symbols per periodic-mode frame.
- BURST_START, 247: frame position of the first corrupted symbol (periodic mode).
- BURST_LEN, 9: corrupted symbols per burst; BURST_START+BURST_LEN <= PERIOD, checked at elaboration.
- FLIP_MASK, all ones: XOR pattern applied to a symbol in burst modes.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_mode_i  in  2  mode: 0 OFF, 1 PERIODIC, 2 RANDOM, 3 ONESHOT.
- cfg_thresh_i  in  8  random-mode flip threshold.
- arm_i  in  1  one-cycle pulse that arms a one-shot burst.
- valid_i  in  1  sym_i is valid this cycle.
- sym_i  in  SYM_W  clean symbol from the encoder.
- valid_o  out  1  sym_o is valid.
- sym_o  out  SYM_W  channel output to the decoder.
- err_o  out  1  sym_o differs from its sym_i.
- flip_ct_o  out  32  total bits flipped; saturating.
- sym_ct_o  out  32  total valid symbols passed; saturating.

## Operation
- Per valid_i, the block computes flip vector f; the output is sym_o = sym_i ^ f and err_o = |f.
- With valid_i low, the internal state holds and valid_o goes low next cycle.
- pos (0..PERIOD-1) increments on each valid_i and wraps to 0 after PERIOD-1.
- pos counts in all modes, so periodic alignment is independent of mode history.
- The 16-bit Galois LFSR uses taps 16'hB400.
  - It advances on every valid_i in all modes.
  - Decisions use its value before the advance.
- Mode behaviour:
  - OFF: f = 0.
  - PERIODIC: f = FLIP_MASK when BURST_START <= pos <= BURST_START+BURST_LEN-1, else 0.
  - RANDOM: when lfsr[7:0] < cfg_thresh_i, f has one bit set at index lfsr[15:8] mod SYM_W, else f = 0.
    - cfg_thresh_i = 0 never flips; 255 flips at rate 255/256.
  - ONESHOT: state machine IDLE -> ARMED -> BURST -> DONE.
    - arm_i in IDLE or DONE moves to ARMED.
    - The next valid_i enters BURST, and that symbol is the first corrupted.
    - BURST applies FLIP_MASK to BURST_LEN consecutive valid symbols, then moves to DONE.
    - arm_i in ARMED or BURST is ignored.
    - f = 0 outside BURST.
- A change of cfg_mode_i takes effect on the next valid_i:
  - any one-shot burst in progress is aborted and the state goes to IDLE;
  - pos and the LFSR are not disturbed.
- flip_ct_o adds popcount(f) and sym_ct_o adds 1 per valid_i. Both saturate at 32'hFFFF_FFFF.

## Timing
- Latency is one cycle: valid_o, sym_o and err_o are registered from the valid_i cycle.
- There is no back-pressure; a new symbol may arrive every cycle.
- Reset values:
  - valid_o = 0, sym_o = 0, err_o = 0;
  - flip_ct_o = 0, sym_ct_o = 0;
  - pos = 0, LFSR = LFSR_SEED, one-shot state IDLE.
- Reset asserted mid-burst clears everything immediately. The burst does not resume after reset releases.
- arm_i and valid_i in the same cycle, from IDLE: the state goes to ARMED only. Corruption starts on the following valid_i.
- The counters are visible one cycle after the valid_i that updated them, aligned with the matching valid_o.

## Configuration
- ERR_INJ_STATS_EN defined: flip_ct_o and sym_ct_o are implemented as described above.
- ERR_INJ_STATS_EN undefined: both counters are removed and flip_ct_o and sym_ct_o are tied to 32'd0. Datapath and err_o are unchanged.

## Structure
- Package err_inj_pkg holds:
  - typedef enum err_mode_t (OFF, PERIODIC, RANDOM, ONESHOT);
  - typedef enum oneshot_state_t (IDLE, ARMED, BURST, DONE);
  - localparam LFSR_TAPS = 16'hB400 and default LFSR_SEED.
- Sub-module err_inj_lfsr: 16-bit Galois LFSR with seed parameter, advance enable and state output.

## Test plan
- Reset, then 300 symbols at default parameters, mode PERIODIC, valid_i every cycle:
  - exactly symbols 247..255 are inverted (sym_o = ~sym_i), with err_o high on those 9 only;
  - flip_ct_o = 18 after symbol 255.
- Mode OFF, 1000 symbols: sym_o equals sym_i delayed 1 cycle, err_o never high, flip_ct_o = 0, sym_ct_o = 1000.
- Mode ONESHOT, arm_i pulsed at symbol 10:
  - the next 9 valid symbols are corrupted;
  - a second arm_i during the burst has no effect;
  - re-arm from DONE gives another 9, so flip_ct_o = 36.
- Mode RANDOM, thresh 0 then 255, 4096 symbols each:
  - zero flips at thresh 0;
  - about 4080 single-bit flips at 255, matching a reference LFSR model bit-exact.
- Assert rst mid-burst at symbol 250 in PERIODIC mode:
  - outputs and counters read 0;
  - after release, pos restarts and the first corruption is at symbol 247 again.
- With valid_i toggling 1/0: pos, the LFSR and the counters advance only on valid cycles, and valid_o mirrors valid_i one cycle later.
